// File: rtl/e_mdu_if.sv
// Bus between the E stage and the multiply/divide unit.
// The E stage drives the request side; the MDU returns busy, HI/LO and the
// mfhi/mflo read value.
interface e_mdu_if;
  logic        start;
  logic [3:0]  MDUOp;
  logic [31:0] A;
  logic [31:0] B;
  logic        busy;
  logic [31:0] HI;
  logic [31:0] LO;
  logic [31:0] MDUOut;

  modport master (
    output start, MDUOp, A, B,
    input  busy, HI, LO, MDUOut
  );

  modport slave (
    input  start, MDUOp, A, B,
    output busy, HI, LO, MDUOut
  );
endinterface

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit.
// The result is computed in the accept cycle and parked in tmp_hi/tmp_lo.
// A down-counter then models the multi-cycle latency, and HI/LO are committed
// on the last busy cycle.
//
// state | meaning
// IDLE  | cnt == 0, unit free: accepts mult/div and mthi/mtlo
// RUN   | cnt  > 0, operation in flight, busy asserted, HI/LO frozen
module e_mdu #(
  parameter int unsigned MULT_CYCLES = 5,
  parameter int unsigned DIV_CYCLES  = 10
) (
  input logic     clk,
  input logic     reset,
  e_mdu_if.slave  mdu_bus
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  localparam logic [3:0] C_MULT_CNT = 4'(MULT_CYCLES);
  localparam logic [3:0] C_DIV_CNT  = 4'(DIV_CYCLES);

  logic [3:0]  r_cnt;
  logic [31:0] r_tmp_hi;
  logic [31:0] r_tmp_lo;
  logic        r_div_zero;
  logic [31:0] r_hi;
  logic [31:0] r_lo;

  logic [3:0]  w_cnt_nxt;
  logic [31:0] w_tmp_hi_nxt;
  logic [31:0] w_tmp_lo_nxt;
  logic        w_div_zero_nxt;
  logic [31:0] w_hi_nxt;
  logic [31:0] w_lo_nxt;

  state_t      w_state;
  logic        w_is_mult;
  logic        w_is_div;
  logic        w_accept;
  logic        w_b_zero;
  logic        w_sdiv_ovf;
  logic [31:0] w_divisor;
  logic [63:0] w_prod_s;
  logic [63:0] w_prod_u;
  logic [31:0] w_quot_s;
  logic [31:0] w_rem_s;
  logic [31:0] w_quot_u;
  logic [31:0] w_rem_u;
  logic [31:0] w_res_hi;
  logic [31:0] w_res_lo;

  assign w_state   = (r_cnt != 4'd0) ? S_RUN : S_IDLE;
  assign w_is_mult = (mdu_bus.MDUOp == OP_MULT) || (mdu_bus.MDUOp == OP_MULTU);
  assign w_is_div  = (mdu_bus.MDUOp == OP_DIV)  || (mdu_bus.MDUOp == OP_DIVU);
  assign w_accept  = mdu_bus.start && (w_state == S_IDLE) && (w_is_mult || w_is_div);

  // Divisor is forced to 1 for B=0 (result discarded anyway) and for the
  // signed overflow case, where A/1 yields exactly LO=0x80000000, HI=0.
  assign w_b_zero   = (mdu_bus.B == 32'd0);
  assign w_sdiv_ovf = (mdu_bus.A == 32'h8000_0000) && (mdu_bus.B == 32'hFFFF_FFFF);
  assign w_divisor  = (w_b_zero || w_sdiv_ovf) ? 32'd1 : mdu_bus.B;

  assign w_prod_s = $signed({{32{mdu_bus.A[31]}}, mdu_bus.A}) *
                    $signed({{32{mdu_bus.B[31]}}, mdu_bus.B});
  assign w_prod_u = {32'd0, mdu_bus.A} * {32'd0, mdu_bus.B};
  assign w_quot_s = $signed(mdu_bus.A) / $signed(w_divisor);
  assign w_rem_s  = $signed(mdu_bus.A) % $signed(w_divisor);
  assign w_quot_u = mdu_bus.A / w_divisor;
  assign w_rem_u  = mdu_bus.A % w_divisor;

  // Select the arithmetic result for the requested operation.
  always_comb begin
    w_res_hi = 32'd0;
    w_res_lo = 32'd0;
    case (mdu_bus.MDUOp)
      OP_MULT: begin
        w_res_hi = w_prod_s[63:32];
        w_res_lo = w_prod_s[31:0];
      end
      OP_MULTU: begin
        w_res_hi = w_prod_u[63:32];
        w_res_lo = w_prod_u[31:0];
      end
      OP_DIV: begin
        w_res_hi = w_rem_s;
        w_res_lo = w_quot_s;
      end
      OP_DIVU: begin
        w_res_hi = w_rem_u;
        w_res_lo = w_quot_u;
      end
      default: begin
        w_res_hi = 32'd0;
        w_res_lo = 32'd0;
      end
    endcase
  end

  // Next-state logic: accept / mthi / mtlo in IDLE, count down and commit in RUN.
  always_comb begin
    w_cnt_nxt      = r_cnt;
    w_tmp_hi_nxt   = r_tmp_hi;
    w_tmp_lo_nxt   = r_tmp_lo;
    w_div_zero_nxt = r_div_zero;
    w_hi_nxt       = r_hi;
    w_lo_nxt       = r_lo;
    case (w_state)
      S_IDLE: begin
        if (w_accept) begin
          w_cnt_nxt      = w_is_mult ? C_MULT_CNT : C_DIV_CNT;
          w_tmp_hi_nxt   = w_res_hi;
          w_tmp_lo_nxt   = w_res_lo;
          w_div_zero_nxt = w_is_div && w_b_zero;
        end else if (!mdu_bus.start && (mdu_bus.MDUOp == OP_MTHI)) begin
          w_hi_nxt = mdu_bus.A;
        end else if (!mdu_bus.start && (mdu_bus.MDUOp == OP_MTLO)) begin
          w_lo_nxt = mdu_bus.A;
        end
      end
      S_RUN: begin
        w_cnt_nxt = r_cnt - 4'd1;
        if ((r_cnt == 4'd1) && !r_div_zero) begin
          w_hi_nxt = r_tmp_hi;
          w_lo_nxt = r_tmp_lo;
        end
      end
      default: begin
        w_cnt_nxt = 4'd0;
      end
    endcase
  end

  // State registers; reset aborts any operation without committing it.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_cnt      <= 4'd0;
      r_tmp_hi   <= 32'd0;
      r_tmp_lo   <= 32'd0;
      r_div_zero <= 1'b0;
      r_hi       <= 32'd0;
      r_lo       <= 32'd0;
    end else begin
      r_cnt      <= w_cnt_nxt;
      r_tmp_hi   <= w_tmp_hi_nxt;
      r_tmp_lo   <= w_tmp_lo_nxt;
      r_div_zero <= w_div_zero_nxt;
      r_hi       <= w_hi_nxt;
      r_lo       <= w_lo_nxt;
    end
  end

  // mfhi/mflo read the architectural registers directly, no pending-result bypass.
  always_comb begin
    mdu_bus.MDUOut = 32'd0;
    if (mdu_bus.MDUOp == OP_MFHI) begin
      mdu_bus.MDUOut = r_hi;
    end else if (mdu_bus.MDUOp == OP_MFLO) begin
      mdu_bus.MDUOut = r_lo;
    end
  end

  assign mdu_bus.busy = (w_state == S_RUN);
  assign mdu_bus.HI   = r_hi;
  assign mdu_bus.LO   = r_lo;

endmodule
